// File: rtl/conv2_pkg.sv
// conv2_pkg: shared constants and helpers for the conv2 window buffer.
//   CONV2_DATA_W  pixel width
//   CONV2_IMG_W   input feature-map side
//   CONV2_K       window side
//   CONV2_TAPS    taps per channel window
//   conv2_tap_index(k, img_w) maps window tap k to its shift-register entry.
package conv2_pkg;

    localparam int unsigned CONV2_DATA_W = 12;
    localparam int unsigned CONV2_IMG_W  = 12;
    localparam int unsigned CONV2_K      = 5;
    localparam int unsigned CONV2_TAPS   = CONV2_K * CONV2_K;

    // Tap k (row-major, top-left = 0) sits (K-1-r) rows and (K-1-c) pixels
    // behind the newest pixel in the raster-ordered shift register.
    function automatic int unsigned conv2_tap_index(input int unsigned k,
                                                    input int unsigned img_w);
        int unsigned r;
        int unsigned c;
        r = k / CONV2_K;
        c = k % CONV2_K;
        return (CONV2_K - 1 - r) * img_w + (CONV2_K - 1 - c);
    endfunction

endpackage

// File: rtl/conv2_line_shift.sv
// conv2_line_shift: one channel of line buffering for the 5x5 window.
// Holds (K-1) full rows plus K pixels; entry 0 is the newest pixel.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears every entry)
//   shift_en    advance the register by one pixel
//   din         incoming pixel
//   taps        25 window taps, straight from register entries
module conv2_line_shift
    import conv2_pkg::*;
#(
    parameter int unsigned DATA_W = CONV2_DATA_W,
    parameter int unsigned IMG_W  = CONV2_IMG_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  shift_en,
    input  logic [DATA_W-1:0]                     din,
    output logic [CONV2_TAPS-1:0][DATA_W-1:0]     taps
);

    localparam int unsigned DEPTH = (CONV2_K - 1) * IMG_W + CONV2_K;

    logic [DATA_W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else if (shift_en) begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < CONV2_TAPS; k++) begin : g_tap
        assign taps[k] = sr_q[conv2_tap_index(k, IMG_W)];
    end

endmodule

// File: rtl/conv2_window_buf.sv
// conv2_window_buf: streaming 5x5 window generator for three channels.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   valid_in              pixel accept strobe (one pixel per channel)
//   data_in1..3           channel pixels, signed
//   valid_out_buf         one-cycle strobe per fully populated window
//   data_outC_k           tap k (row-major, 0 = top-left) of channel C
module conv2_window_buf
    import conv2_pkg::*;
#(
    parameter int unsigned DATA_W = CONV2_DATA_W,
    parameter int unsigned IMG_W  = CONV2_IMG_W,
    parameter int unsigned K      = CONV2_K
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] data_in1,
    input  logic signed [DATA_W-1:0] data_in2,
    input  logic signed [DATA_W-1:0] data_in3,
    output logic                     valid_out_buf,
    output logic signed [DATA_W-1:0] data_out1_0,  data_out1_1,  data_out1_2,  data_out1_3,
    output logic signed [DATA_W-1:0] data_out1_4,  data_out1_5,  data_out1_6,  data_out1_7,
    output logic signed [DATA_W-1:0] data_out1_8,  data_out1_9,  data_out1_10, data_out1_11,
    output logic signed [DATA_W-1:0] data_out1_12, data_out1_13, data_out1_14, data_out1_15,
    output logic signed [DATA_W-1:0] data_out1_16, data_out1_17, data_out1_18, data_out1_19,
    output logic signed [DATA_W-1:0] data_out1_20, data_out1_21, data_out1_22, data_out1_23,
    output logic signed [DATA_W-1:0] data_out1_24,
    output logic signed [DATA_W-1:0] data_out2_0,  data_out2_1,  data_out2_2,  data_out2_3,
    output logic signed [DATA_W-1:0] data_out2_4,  data_out2_5,  data_out2_6,  data_out2_7,
    output logic signed [DATA_W-1:0] data_out2_8,  data_out2_9,  data_out2_10, data_out2_11,
    output logic signed [DATA_W-1:0] data_out2_12, data_out2_13, data_out2_14, data_out2_15,
    output logic signed [DATA_W-1:0] data_out2_16, data_out2_17, data_out2_18, data_out2_19,
    output logic signed [DATA_W-1:0] data_out2_20, data_out2_21, data_out2_22, data_out2_23,
    output logic signed [DATA_W-1:0] data_out2_24,
    output logic signed [DATA_W-1:0] data_out3_0,  data_out3_1,  data_out3_2,  data_out3_3,
    output logic signed [DATA_W-1:0] data_out3_4,  data_out3_5,  data_out3_6,  data_out3_7,
    output logic signed [DATA_W-1:0] data_out3_8,  data_out3_9,  data_out3_10, data_out3_11,
    output logic signed [DATA_W-1:0] data_out3_12, data_out3_13, data_out3_14, data_out3_15,
    output logic signed [DATA_W-1:0] data_out3_16, data_out3_17, data_out3_18, data_out3_19,
    output logic signed [DATA_W-1:0] data_out3_20, data_out3_21, data_out3_22, data_out3_23,
    output logic signed [DATA_W-1:0] data_out3_24
);

    localparam int unsigned CNT_W = $clog2(IMG_W);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             valid_q, valid_d;

    logic [CONV2_TAPS-1:0][DATA_W-1:0] taps1, taps2, taps3;

    // Counters hold the position of the pixel that the next accept will take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (col_q == CNT_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == CNT_W'(IMG_W - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // A window is complete once the accepted pixel is at least K-1 in from
    // the top and left edges; only then does the bottom-right tap close it.
    assign valid_d = valid_in && (col_q >= CNT_W'(K - 1)) && (row_q >= CNT_W'(K - 1));

    assign valid_out_buf = valid_q;

    conv2_line_shift #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_ch1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (valid_in),
        .din      (data_in1),
        .taps     (taps1)
    );

    conv2_line_shift #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_ch2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (valid_in),
        .din      (data_in2),
        .taps     (taps2)
    );

    conv2_line_shift #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_ch3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (valid_in),
        .din      (data_in3),
        .taps     (taps3)
    );

    assign data_out1_0  = taps1[0];
    assign data_out1_1  = taps1[1];
    assign data_out1_2  = taps1[2];
    assign data_out1_3  = taps1[3];
    assign data_out1_4  = taps1[4];
    assign data_out1_5  = taps1[5];
    assign data_out1_6  = taps1[6];
    assign data_out1_7  = taps1[7];
    assign data_out1_8  = taps1[8];
    assign data_out1_9  = taps1[9];
    assign data_out1_10 = taps1[10];
    assign data_out1_11 = taps1[11];
    assign data_out1_12 = taps1[12];
    assign data_out1_13 = taps1[13];
    assign data_out1_14 = taps1[14];
    assign data_out1_15 = taps1[15];
    assign data_out1_16 = taps1[16];
    assign data_out1_17 = taps1[17];
    assign data_out1_18 = taps1[18];
    assign data_out1_19 = taps1[19];
    assign data_out1_20 = taps1[20];
    assign data_out1_21 = taps1[21];
    assign data_out1_22 = taps1[22];
    assign data_out1_23 = taps1[23];
    assign data_out1_24 = taps1[24];

    assign data_out2_0  = taps2[0];
    assign data_out2_1  = taps2[1];
    assign data_out2_2  = taps2[2];
    assign data_out2_3  = taps2[3];
    assign data_out2_4  = taps2[4];
    assign data_out2_5  = taps2[5];
    assign data_out2_6  = taps2[6];
    assign data_out2_7  = taps2[7];
    assign data_out2_8  = taps2[8];
    assign data_out2_9  = taps2[9];
    assign data_out2_10 = taps2[10];
    assign data_out2_11 = taps2[11];
    assign data_out2_12 = taps2[12];
    assign data_out2_13 = taps2[13];
    assign data_out2_14 = taps2[14];
    assign data_out2_15 = taps2[15];
    assign data_out2_16 = taps2[16];
    assign data_out2_17 = taps2[17];
    assign data_out2_18 = taps2[18];
    assign data_out2_19 = taps2[19];
    assign data_out2_20 = taps2[20];
    assign data_out2_21 = taps2[21];
    assign data_out2_22 = taps2[22];
    assign data_out2_23 = taps2[23];
    assign data_out2_24 = taps2[24];

    assign data_out3_0  = taps3[0];
    assign data_out3_1  = taps3[1];
    assign data_out3_2  = taps3[2];
    assign data_out3_3  = taps3[3];
    assign data_out3_4  = taps3[4];
    assign data_out3_5  = taps3[5];
    assign data_out3_6  = taps3[6];
    assign data_out3_7  = taps3[7];
    assign data_out3_8  = taps3[8];
    assign data_out3_9  = taps3[9];
    assign data_out3_10 = taps3[10];
    assign data_out3_11 = taps3[11];
    assign data_out3_12 = taps3[12];
    assign data_out3_13 = taps3[13];
    assign data_out3_14 = taps3[14];
    assign data_out3_15 = taps3[15];
    assign data_out3_16 = taps3[16];
    assign data_out3_17 = taps3[17];
    assign data_out3_18 = taps3[18];
    assign data_out3_19 = taps3[19];
    assign data_out3_20 = taps3[20];
    assign data_out3_21 = taps3[21];
    assign data_out3_22 = taps3[22];
    assign data_out3_23 = taps3[23];
    assign data_out3_24 = taps3[24];

endmodule

// File: tb/tb_conv2_window_buf.sv
// Self-checking bench for conv2_window_buf: a 2D frame-image model predicts
// window validity and tap contents; a small table pins known ramp values.
module tb_conv2_window_buf;

    localparam int DW = 12;
    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] d1 = '0, d2 = '0, d3 = '0;
    logic          valid_out_buf;
    logic [DW-1:0] t1 [25];
    logic [DW-1:0] t2 [25];
    logic [DW-1:0] t3 [25];

    always #5 clk = ~clk;

    conv2_window_buf dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_in1(d1), .data_in2(d2), .data_in3(d3), .valid_out_buf(valid_out_buf),
        .data_out1_0(t1[0]),   .data_out1_1(t1[1]),   .data_out1_2(t1[2]),
        .data_out1_3(t1[3]),   .data_out1_4(t1[4]),   .data_out1_5(t1[5]),
        .data_out1_6(t1[6]),   .data_out1_7(t1[7]),   .data_out1_8(t1[8]),
        .data_out1_9(t1[9]),   .data_out1_10(t1[10]), .data_out1_11(t1[11]),
        .data_out1_12(t1[12]), .data_out1_13(t1[13]), .data_out1_14(t1[14]),
        .data_out1_15(t1[15]), .data_out1_16(t1[16]), .data_out1_17(t1[17]),
        .data_out1_18(t1[18]), .data_out1_19(t1[19]), .data_out1_20(t1[20]),
        .data_out1_21(t1[21]), .data_out1_22(t1[22]), .data_out1_23(t1[23]),
        .data_out1_24(t1[24]),
        .data_out2_0(t2[0]),   .data_out2_1(t2[1]),   .data_out2_2(t2[2]),
        .data_out2_3(t2[3]),   .data_out2_4(t2[4]),   .data_out2_5(t2[5]),
        .data_out2_6(t2[6]),   .data_out2_7(t2[7]),   .data_out2_8(t2[8]),
        .data_out2_9(t2[9]),   .data_out2_10(t2[10]), .data_out2_11(t2[11]),
        .data_out2_12(t2[12]), .data_out2_13(t2[13]), .data_out2_14(t2[14]),
        .data_out2_15(t2[15]), .data_out2_16(t2[16]), .data_out2_17(t2[17]),
        .data_out2_18(t2[18]), .data_out2_19(t2[19]), .data_out2_20(t2[20]),
        .data_out2_21(t2[21]), .data_out2_22(t2[22]), .data_out2_23(t2[23]),
        .data_out2_24(t2[24]),
        .data_out3_0(t3[0]),   .data_out3_1(t3[1]),   .data_out3_2(t3[2]),
        .data_out3_3(t3[3]),   .data_out3_4(t3[4]),   .data_out3_5(t3[5]),
        .data_out3_6(t3[6]),   .data_out3_7(t3[7]),   .data_out3_8(t3[8]),
        .data_out3_9(t3[9]),   .data_out3_10(t3[10]), .data_out3_11(t3[11]),
        .data_out3_12(t3[12]), .data_out3_13(t3[13]), .data_out3_14(t3[14]),
        .data_out3_15(t3[15]), .data_out3_16(t3[16]), .data_out3_17(t3[17]),
        .data_out3_18(t3[18]), .data_out3_19(t3[19]), .data_out3_20(t3[20]),
        .data_out3_21(t3[21]), .data_out3_22(t3[22]), .data_out3_23(t3[23]),
        .data_out3_24(t3[24])
    );

    typedef struct {
        int            idx;  // accept index within the frame
        int            off;  // ramp offset of the frame
        int            ch;   // 1..3
        int            tap;
        logic [DW-1:0] exp;
    } tap_vec_t;

    tap_vec_t tv [12];

    int n_vec = 0;
    int n_bad = 0;
    int pulses = 0;

    // Reference model: the current frame as a 2D image plus raster position.
    logic [DW-1:0] img [3][IW][IW];
    int  mx, my, lx, ly;
    bit  have_last, exp_valid;

    function automatic logic [DW-1:0] dut_tap(input int ch, input int k);
        if (ch == 1) return t1[k];
        if (ch == 2) return t2[k];
        return t3[k];
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; have_last = 0; exp_valid = 0;
    endtask

    task automatic check_now();
        bit            bad;
        int            bch, bk;
        logic [DW-1:0] ba, be;
        n_vec++;
        if (valid_out_buf !== exp_valid) begin
            n_bad++;
            $display("FAIL valid t=%0t got=%b want=%b", $time, valid_out_buf, exp_valid);
        end
        if (valid_out_buf === 1'b1) pulses++;
        // The window around the last accept is predictable whenever it lies
        // fully inside the current frame, valid strobe or stall alike.
        if (have_last && lx >= 4 && ly >= 4) begin
            bad = 0;
            for (int ch = 1; ch <= 3; ch++) begin
                for (int k = 0; k < 25; k++) begin
                    logic [DW-1:0] e, a;
                    e = img[ch-1][ly-4+k/5][lx-4+k%5];
                    a = dut_tap(ch, k);
                    if (a !== e && !bad) begin
                        bad = 1; bch = ch; bk = k; ba = a; be = e;
                    end
                end
            end
            n_vec++;
            if (bad) begin
                n_bad++;
                $display("FAIL window (%0d,%0d) ch%0d tap%0d got=%h want=%h",
                         lx, ly, bch, bk, ba, be);
            end
        end
    endtask

    task automatic check_zero();
        bit bad;
        bad = (valid_out_buf !== 1'b0);
        for (int k = 0; k < 25; k++) begin
            if (t1[k] !== '0 || t2[k] !== '0 || t3[k] !== '0) bad = 1;
        end
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL reset_state got valid=%b t1_24=%h t2_24=%h t3_0=%h want all 0",
                     valid_out_buf, t1[24], t2[24], t3[0]);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c);
        valid_in = v; d1 = a; d2 = b; d3 = c;
        @(posedge clk);
        if (v) begin
            img[0][my][mx] = a;
            img[1][my][mx] = b;
            img[2][my][mx] = c;
            lx = mx; ly = my; have_last = 1;
            exp_valid = (mx >= 4 && my >= 4);
            mx++;
            if (mx == IW) begin
                mx = 0;
                my = (my == IW - 1) ? 0 : my + 1;
            end
        end else begin
            exp_valid = 0;
        end
        @(negedge clk);
        check_now();
    endtask

    // Ramp frame: ch1 = idx+off, ch2 = -(idx+off), ch3 = 0x7FF; runs accepts 0..last.
    task automatic run_frame(input int off, input bit stall, input int last);
        int            acc, cyc;
        bit            v;
        logic [DW-1:0] p, np;
        acc = 0; cyc = 0;
        while (acc <= last && cyc < 5000) begin
            v = stall ? ($urandom_range(1, 0) == 1) : 1'b1;
            p = DW'(acc + off);
            np = -p;
            step(v, p, np, 12'h7FF);
            if (v) begin
                for (int i = 0; i < 12; i++) begin
                    if (tv[i].idx == acc && tv[i].off == off) begin
                        logic [DW-1:0] a;
                        a = dut_tap(tv[i].ch, tv[i].tap);
                        n_vec++;
                        if (a !== tv[i].exp) begin
                            n_bad++;
                            $display("FAIL table idx%0d ch%0d tap%0d got=%h want=%h",
                                     acc, tv[i].ch, tv[i].tap, a, tv[i].exp);
                        end
                    end
                end
                acc++;
            end
            cyc++;
        end
        if (acc <= last) begin
            n_vec++; n_bad++;
            $display("FAIL frame_timeout got=%0d accepts want=%0d", acc, last + 1);
        end
        valid_in = 0;
    endtask

    task automatic check_pulses(input int want);
        n_vec++;
        if (pulses != want) begin
            n_bad++;
            $display("FAIL pulse_count got=%0d want=%0d", pulses, want);
        end
    endtask

    initial begin
        tv[0]  = '{52,  0,    1, 0,  12'd0};
        tv[1]  = '{52,  0,    1, 4,  12'd4};
        tv[2]  = '{52,  0,    1, 12, 12'd26};
        tv[3]  = '{52,  0,    1, 20, 12'd48};
        tv[4]  = '{52,  0,    1, 24, 12'd52};
        tv[5]  = '{52,  0,    2, 24, 12'hFCC};
        tv[6]  = '{52,  0,    3, 0,  12'h7FF};
        tv[7]  = '{143, 0,    1, 24, 12'd143};
        tv[8]  = '{143, 0,    1, 0,  12'd91};
        tv[9]  = '{143, 0,    2, 0,  12'hFA5};
        tv[10] = '{52,  1000, 1, 24, 12'd1052};
        tv[11] = '{52,  1000, 1, 0,  12'd1000};

        model_reset();
        repeat (2) @(negedge clk);
        check_zero();
        rst_n = 1;

        // Unstalled ramp frame, then idle cycles that must hold the last window.
        pulses = 0;
        run_frame(0, 0, 143);
        repeat (3) step(0, 12'h123, 12'h456, 12'h789);
        check_pulses(64);

        // Same frame with random stalls.
        pulses = 0;
        run_frame(0, 1, 143);
        repeat (2) step(0, 12'h0, 12'h0, 12'h0);
        check_pulses(64);

        // Back-to-back frames, second one offset.
        pulses = 0;
        run_frame(0, 0, 143);
        run_frame(1000, 0, 143);
        check_pulses(128);

        // Reset in the middle of a frame.
        run_frame(0, 0, 70);
        rst_n = 0;
        #1;
        check_zero();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        pulses = 0;
        run_frame(0, 0, 143);
        step(0, 12'h0, 12'h0, 12'h0);
        check_pulses(64);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/conv2_window_buf.md
# conv2_window_buf

Streaming 5x5 window generator feeding the conv2 calculation units. Accepts the three-channel 12x12 conv1/pool feature map in raster order, one pixel per channel per accepted cycle. Holds four full rows plus five pixels per channel in shift registers. Presents all 75 window taps with a one-cycle `valid_out_buf` strobe for every fully populated window, so each conv2_calc_* instance sees an 8x8 output grid per frame.

## Interface
Parameters:
- `DATA_W`, 12: pixel width, signed two's complement.
- `IMG_W`, 12: square input map side; rows = cols = `IMG_W`.
- `K`, 5: window side; fixed at 5 because the tap port list is 5x5.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `valid_in` in 1: input pixel strobe; one pixel per channel is accepted on each cycle it is high.
- `data_in1`, `data_in2`, `data_in3` in `DATA_W` (signed): channel 1/2/3 pixel.
- `valid_out_buf` out 1: window-valid strobe.
- `data_outC_k` out `DATA_W` (signed), for C in 1..3 and k in 0..24: window tap k of channel C. Taps are row-major with top-left = 0 and bottom-right = 24.

## Operation
- Counters `col_cnt` and `row_cnt` run 0..`IMG_W`-1 and track the position (x,y) of the pixel being accepted.
- On accept: `col_cnt` increments. When it wraps to 0, `row_cnt` increments. When both wrap, the frame ends and the next accepted pixel is (0,0) of a new frame. There is no frame-start input.
- Per channel, a shift register of depth (K-1)*IMG_W+K = 53 entries: `sr[0]` is the newest pixel and shift occurs only on accept. No shift while `valid_in` is low.
- Tap mapping, with r=k/5 and c=k%5: `data_outC_k` = `srC[(4-r)*IMG_W + (4-c)]`. This is the pixel at (x-4+c, y-4+r) relative to the most recently accepted pixel (x,y).
- Taps are driven directly from shift-register flops, with no combinational arithmetic on the path.
- Window valid condition, evaluated on the accept of pixel (x,y): x>=4 and y>=4. This gives 64 windows per frame; the first is at (4,4), which is accepted pixel index 52, and the last is at (11,11).
- Channels share counters and valid. Data paths are independent and carried bit-exact with no rescaling.
- No backpressure. The downstream calc pipelines accept a window every cycle.

## Timing
- Reset (async assert): all shift-register entries = 0, so every `data_outC_k` = 0. Also `valid_out_buf` = 0 and both counters = 0. Release is synchronous to `clk` through the standard reset synchronizer upstream.
- Latency: an accept that completes a window at edge t gives `valid_out_buf` = 1 and the corresponding taps during the cycle after edge t, i.e. 1 cycle.
- `valid_out_buf` is a registered, single-cycle pulse per qualifying accept. Back-to-back qualifying accepts produce back-to-back pulses: 8 consecutive per row when input is unstalled.
- Stall (`valid_in` = 0): `valid_out_buf` = 0 next cycle, and taps hold their values unchanged.
- Taps are don't-care whenever `valid_out_buf` = 0. At the start of a frame they contain data from the previous frame, which is expected and is never flagged valid.
- Frame wrap: the accept of (11,11) produces the last valid. The accept of (0,0) of the next frame is never valid, and the first window of the new frame is again at its pixel index 52.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is (0,0).

## Structure
- Shared package `conv2_pkg`:
  - constants `CONV2_DATA_W` = 12, `CONV2_IMG_W` = 12, `CONV2_K` = 5, `CONV2_TAPS` = 25;
  - a constant function giving the tap-to-shift-register index ((4-r)*IMG_W + (4-c)).
- Sub-module `conv2_line_shift`: one channel, a 53-deep x `DATA_W` shift register with shift enable, exposing the 25 tap outputs. Instantiated 3x.
- The top level owns the counters and the valid logic.

## Test plan
- Ramp frame: ch1 pixel = y*12+x, `valid_in` held high for 144 cycles. Expected:
  - the first `valid_out_buf` arrives the cycle after accept index 52, with `data_out1_0`=0, `data_out1_4`=4, `data_out1_12`=26, `data_out1_20`=48, `data_out1_24`=52;
  - exactly 64 pulses occur;
  - the last pulse has `data_out1_24`=143 and `data_out1_0`=91.
- Channel independence: ch2 = -(y*12+x) and ch3 = 0x7FF for all pixels. At every valid, `data_out2_k` = -`data_out1_k` and `data_out3_k` = 0x7FF (sign preserved, e.g. ch2 pixel 52 reads 0xFCC).
- Random stalls: `valid_in` is high with probability 0.5, using the ramp data. Expected:
  - the sequence of valid windows is identical to the unstalled run;
  - taps hold during stalls;
  - there is never a pulse on a cycle following a non-accept.
- Back-to-back frames: two ramp frames with the second offset by +1000. Expected:
  - 128 pulses in total;
  - no pulse during accepts 0..51 of frame 2;
  - frame-2 first window has `data_out1_24` = 1052.
- Reset mid-frame: assert `rst_n` = 0 after accept index 70. Expected:
  - `valid_out_buf` and all taps read 0 immediately;
  - after release, a fresh ramp produces its first valid after index 52, with values identical to the first test.
